// File: rtl/spi_arb_pkg.sv
// spi_master_arbiter shared types: FSM state and counter width helper.
// Optional watchdog macro: SPI_ARB_TIMEOUT_EN (see spi_master_arbiter.sv).
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Counter must hold both the gap reload and the watchdog limit.
    function automatic int calc_cnt_w(input int gap, input int tmo);
        int m;
        m = (gap > tmo) ? gap : tmo;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first request above ptr, wrapping.
// Produces both a one-hot grant and its index.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] idx;
    logic          found;

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the last winner goes last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt     = N_REQ'(1) << idx;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master between N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to enable the BUSY watchdog (resp_err).
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]       resp_data,
    output logic                        resp_err,
    output logic [N_REQ-1:0]            spi_cs_n,
    output logic                        busy,
    output logic                        spi_m_start,
    output logic [DATA_WIDTH-1:0]       data_m_send,
    input  logic                        spi_m_done,
    input  logic [DATA_WIDTH-1:0]       data_m_recv
);
    localparam int PW    = $clog2(N_REQ);
    localparam int CNT_W = calc_cnt_w(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYCLES);
    localparam arb_state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_t state_q, state_n;

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]      gnt;
    logic [PW-1:0]         gnt_idx;
    logic [N_REQ-1:0]      own;
    logic [DATA_WIDTH-1:0] send_d, rdata_d;
    logic [N_REQ-1:0]      cs_d, ready_d, rv_d;
    logic                  start_d, err_d, busy_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic tmo_hit;
    assign tmo_hit = (cnt_q == TMO_LAST);
`endif

    assign own = N_REQ'(1) << ptr_q;

    spi_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Next-state: one frame per grant, then the idle gap.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:  if (|req_valid) state_n = START;
            START: state_n = BUSY;
            BUSY: begin
                if (spi_m_done) state_n = POST;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_hit) state_n = POST;
`endif
            end
            GAP:   if (cnt_q == CNT_W'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values for every registered output and the counter.
    always_comb begin
        ptr_d   = ptr_q;
        send_d  = data_m_send;
        cs_d    = spi_cs_n;
        ready_d = '0;
        start_d = 1'b0;
        rv_d    = '0;
        rdata_d = resp_data;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        busy_d  = (state_n != IDLE);
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ptr_d   = gnt_idx;
                    send_d  = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    cs_d    = ~gnt;
                    ready_d = gnt;
                    start_d = 1'b1;
                end
            end
            START: cnt_d = '0;
            BUSY: begin
                if (spi_m_done) begin
                    rdata_d = data_m_recv;
                    rv_d    = own;
                    cs_d    = '1;
                    cnt_d   = GAP_LD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d = '0;
                    rv_d    = own;
                    err_d   = 1'b1;
                    cs_d    = '1;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            GAP: cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Output, pointer and counter registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ptr_q       <= PW'(N_REQ - 1);
            cnt_q       <= '0;
            data_m_send <= '0;
            spi_cs_n    <= '1;
            req_ready   <= '0;
            spi_m_start <= 1'b0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            data_m_send <= send_d;
            spi_cs_n    <= cs_d;
            req_ready   <= ready_d;
            spi_m_start <= start_d;
            resp_valid  <= rv_d;
            resp_data   <= rdata_d;
            resp_err    <= err_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: SPI slave loopback model plus
// a timeline-based reference model of grants, frames and gaps.
module tb_spi_master_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 10;
    localparam int TO  = 50;
    localparam int BIT = 3;

    logic            clk = 1'b0;
    logic            arstn;
    logic [N-1:0]    req_valid, req_ready, resp_valid, spi_cs_n;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   resp_data, data_m_send, data_m_recv;
    logic            resp_err, busy, spi_m_start, spi_m_done;

    always #10 clk = ~clk;

    spi_master_arbiter #(
        .N_REQ          (N),
        .DATA_WIDTH     (DW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .spi_cs_n    (spi_cs_n),
        .busy        (busy),
        .spi_m_start (spi_m_start),
        .data_m_send (data_m_send),
        .spi_m_done  (spi_m_done),
        .data_m_recv (data_m_recv)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model: timeline of grants and frame ends
    int            mptr, g, busy_from, free_at, rel_cyc;
    bit            inflight;
    logic [DW-1:0] g_tx, m_rdata;

    // observations of the DUT
    int            dut_grants[$];
    int            dut_resp_cnt, start_cyc, rv_cyc;
    logic [DW-1:0] last_resp;
    logic          last_err;

    // slave / SPI master model and stimulus controls
    bit            s_act, hang, stray_en, rand_mode, rst_hold, rx_fixed_en;
    int            s_cnt;
    logic [DW-1:0] s_rx, s_got, rx_fixed;
    logic [N-1:0]  hold_v;
    logic [N*DW-1:0] hold_d;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] v, int p);
        int r;
        int j;
        logic [N-1:0] sh;
        r = -1;
        for (int k = 1; k <= N; k++) begin
            j = (p + k) % N;
            sh = v >> j;
            if (r < 0 && sh[0]) r = j;
        end
        return r;
    endfunction

    task automatic drive();
        logic [N-1:0] m;
        arstn = !rst_hold;
        spi_m_done = 1'b0;
        data_m_recv = DW'($urandom);
        if (s_act && !hang) begin
            s_cnt--;
            if (s_cnt == 0) begin
                spi_m_done = 1'b1;
                data_m_recv = s_rx;
                s_act = 1'b0;
            end
        end else if (!s_act && stray_en && $urandom_range(0, 7) == 0) begin
            spi_m_done = 1'b1;
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                m = N'(1) << i;
                if ((req_valid & m) != 0) begin
                    if ((req_ready & m) != 0) begin
                        if ($urandom_range(0, 1) == 0) req_valid = req_valid & ~m;
                        else req_data[i*DW +: DW] = DW'($urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid = req_valid & ~m;
                    end
                end else begin
                    req_data[i*DW +: DW] = DW'($urandom);
                    if ($urandom_range(0, 3) == 0) req_valid = req_valid | m;
                end
            end
        end else begin
            req_valid = hold_v;
            req_data  = hold_d;
        end
    endtask

    task automatic observe();
        logic [N-1:0] e_ready, e_rv, e_cs, sh;
        logic         e_start, e_err, e_busy;
        int           w;
        e_ready = '0;
        e_rv    = '0;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (!arstn) begin
            inflight = 1'b0;
            mptr     = N - 1;
            free_at  = 0;
            rel_cyc  = -1;
            m_rdata  = '0;
        end else if (!inflight && cyc >= free_at && req_valid != 0) begin
            w         = rr_pick(req_valid, mptr);
            mptr      = w;
            g         = w;
            g_tx      = req_data[w*DW +: DW];
            inflight  = 1'b1;
            busy_from = cyc + 2;
            e_ready   = N'(1) << w;
            e_start   = 1'b1;
        end else if (inflight && cyc >= busy_from && spi_m_done) begin
            e_rv     = N'(1) << g;
            m_rdata  = data_m_recv;
            inflight = 1'b0;
            free_at  = cyc + GAP + 1;
            rel_cyc  = cyc;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (inflight && cyc >= busy_from + TO - 1) begin
            e_rv     = N'(1) << g;
            e_err    = 1'b1;
            m_rdata  = '0;
            inflight = 1'b0;
            free_at  = cyc + GAP + 1;
            rel_cyc  = cyc;
        end
`endif
        e_cs   = inflight ? ~(N'(1) << g) : '1;
        e_busy = inflight || (cyc < free_at - 1);
        check("req_ready", req_ready, e_ready);
        check("spi_m_start", spi_m_start, e_start);
        check("resp_valid", resp_valid, e_rv);
        check("resp_err", resp_err, e_err);
        check("resp_data", resp_data, m_rdata);
        check("spi_cs_n", spi_cs_n, e_cs);
        check("busy", busy, e_busy);
        if (inflight) check("data_m_send", data_m_send, g_tx);
        else if (!arstn) check("data_m_send_rst", data_m_send, 0);

        for (int j = 0; j < N; j++) begin
            sh = req_ready >> j;
            if (sh[0]) dut_grants.push_back(j);
        end
        if (spi_m_start) begin
            if (rel_cyc >= 0) check("gap_len", (cyc - rel_cyc) >= GAP + 1, 1);
            start_cyc = cyc;
        end
        if (resp_valid != 0) begin
            dut_resp_cnt++;
            last_resp = resp_data;
            last_err  = resp_err;
            rv_cyc    = cyc;
        end

        if (!arstn) begin
            s_act = 1'b0;
        end else if (spi_m_start) begin
            s_act = 1'b1;
            s_cnt = DW * BIT;
            s_got = data_m_send;
            s_rx  = rx_fixed_en ? rx_fixed : DW'($urandom);
        end else if (s_act && spi_cs_n == '1) begin
            s_act = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        @(posedge clk);
        cyc++;
        #1;
        observe();
    endtask

    task automatic do_reset();
        rst_hold = 1'b1;
        repeat (2) step();
        rst_hold = 1'b0;
        dut_grants.delete();
    endtask

    task automatic run_until_grant(string tag);
        int n0;
        int lim;
        n0 = dut_grants.size();
        lim = 0;
        while (dut_grants.size() == n0 && lim < 2000) begin
            step();
            lim++;
        end
        check({tag, "_grant_seen"}, dut_grants.size() > n0, 1);
    endtask

    task automatic run_until_resp(int n, string tag);
        int target;
        int lim;
        target = dut_resp_cnt + n;
        lim = 0;
        while (dut_resp_cnt < target && lim < 5000) begin
            step();
            lim++;
        end
        check({tag, "_resp_seen"}, dut_resp_cnt >= target, 1);
    endtask

    initial begin
        int exp2[5];
        int exp3[4];
        int c0, n1;
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{0, 2, 0, 2};
        arstn = 1'b0;
        req_valid = '0;
        req_data = '0;
        spi_m_done = 1'b0;
        data_m_recv = '0;
        hold_v = '0;
        hold_d = '0;
        {s_act, hang, stray_en, rand_mode, rx_fixed_en} = '0;
        rx_fixed = '0;
        dut_resp_cnt = 0;
        rel_cyc = -1;

        // reset state
        do_reset();

        // T1: single request AB, slave answers CD
        hold_d[7:0] = 8'hAB;
        hold_v = 4'b0001;
        rx_fixed_en = 1'b1;
        rx_fixed = 8'hCD;
        run_until_grant("t1");
        hold_v = '0;
        run_until_resp(1, "t1");
        check("t1_slave_got", s_got, 8'hAB);
        check("t1_resp_data", last_resp, 8'hCD);
        if (dut_grants.size() > 0) check("t1_grant", dut_grants[0], 0);
        repeat (GAP + 4) step();

        // T2: all four held
        do_reset();
        rx_fixed_en = 1'b0;
        hold_d = {8'h44, 8'h33, 8'h22, 8'h11};
        hold_v = 4'b1111;
        run_until_resp(5, "t2");
        hold_v = '0;
        repeat (GAP + 4) step();
        check("t2_count", dut_grants.size() >= 5, 1);
        for (int k = 0; k < 5; k++)
            if (k < dut_grants.size()) check("t2_order", dut_grants[k], exp2[k]);

        // T3: 0101 held
        do_reset();
        hold_v = 4'b0101;
        run_until_resp(4, "t3");
        hold_v = '0;
        repeat (GAP + 4) step();
        check("t3_count", dut_grants.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (k < dut_grants.size()) check("t3_order", dut_grants[k], exp3[k]);

        // T4: reset in the middle of a frame
        do_reset();
        hold_d[15:8] = 8'h5A;
        hold_v = 4'b0010;
        c0 = 0;
        while (!(s_act && s_cnt <= DW * BIT - 4 * BIT) && c0 < 2000) begin
            step();
            c0++;
        end
        check("t4_mid_frame", s_act, 1);
        hold_v = '0;
        c0 = dut_resp_cnt;
        do_reset();
        check("t4_no_resp", dut_resp_cnt - c0, 0);
        check("t4_cs_n", spi_cs_n, 4'b1111);
        check("t4_busy", busy, 0);
        hold_d[31:24] = 8'h3C;
        hold_v = 4'b1000;
        rx_fixed_en = 1'b1;
        rx_fixed = 8'h96;
        run_until_grant("t4");
        hold_v = '0;
        run_until_resp(1, "t4");
        check("t4_resp_data", last_resp, 8'h96);
        if (dut_grants.size() > 0) check("t4_grant", dut_grants[0], 3);
        repeat (GAP + 4) step();

`ifdef SPI_ARB_TIMEOUT_EN
        // T5: slave never finishes
        do_reset();
        hang = 1'b1;
        hold_d[23:16] = 8'hEE;
        hold_v = 4'b0100;
        run_until_grant("t5");
        hold_v = '0;
        run_until_resp(1, "t5");
        check("t5_err", last_err, 1);
        check("t5_data", last_resp, 0);
        check("t5_latency", rv_cyc - start_cyc - 1, TO);
        hang = 1'b0;
        repeat (GAP + 4) step();
`endif

        // T6: req1 pulsed for one cycle inside the gap
        do_reset();
        rx_fixed_en = 1'b0;
        hold_d[7:0] = 8'h77;
        hold_d[15:8] = 8'h88;
        hold_v = 4'b0001;
        run_until_resp(1, "t6");
        repeat (3) step();
        hold_v = 4'b0011;
        step();
        hold_v = 4'b0001;
        run_until_resp(2, "t6");
        hold_v = '0;
        repeat (GAP + 4) step();
        n1 = 0;
        foreach (dut_grants[k]) if (dut_grants[k] == 1) n1++;
        check("t6_req1_never", n1, 0);

        // random traffic with stray done pulses
        do_reset();
        c0 = dut_resp_cnt;
        rand_mode = 1'b1;
        stray_en = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        stray_en = 1'b0;
        hold_v = '0;
        repeat (100) step();
        check("rand_frames", (dut_resp_cnt - c0) > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
